// File: rtl/mul_acc_stage_if.sv
// Product-stream / result bus between the multiplier and the accumulation stage.
//   master : drives prod_vld, prod_in, clear; observes acc_vld, acc_out, acc_ovf, busy
//   slave  : the accumulation stage itself
interface mul_acc_stage_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned ACC_W = 18
);
  logic             prod_vld;
  logic [IN_W-1:0]  prod_in;
  logic             clear;
  logic             acc_vld;
  logic [ACC_W-1:0] acc_out;
  logic             acc_ovf;
  logic             busy;

  modport master (
    output prod_vld, prod_in, clear,
    input  acc_vld, acc_out, acc_ovf, busy
  );

  modport slave (
    input  prod_vld, prod_in, clear,
    output acc_vld, acc_out, acc_ovf, busy
  );
endinterface

// File: rtl/mul_acc_stage.sv
// Accumulation stage behind the 8-bit pipelined multiplier. Sums every DEPTH valid
// products into one saturating result, emitted with a one-cycle acc_vld pulse.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of mul_acc_stage_if (prod_vld/prod_in/clear in,
//          acc_vld/acc_out/acc_ovf/busy out)
module mul_acc_stage #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ACC_W = 18
) (
  input  logic           clk,
  input  logic           rst,
  mul_acc_stage_if.slave bus
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_q, out_d;
  logic             out_ovf_q, out_ovf_d;
  logic             vld_q, vld_d;

  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] prod_ext;
  logic             sat_ovf;
  logic [ACC_W-1:0] sat_val;

  assign prod_ext = {{(ACC_W - IN_W){1'b0}}, bus.prod_in};
  assign sum      = {1'b0, acc_q} + {1'b0, prod_ext};
  // Saturation is sticky for the rest of the group.
  assign sat_ovf  = sum[ACC_W] | ovf_q;
  assign sat_val  = sat_ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    out_d     = out_q;
    out_ovf_d = out_ovf_q;
    vld_d     = 1'b0;

    if (bus.clear) begin
      // Abort wins over a simultaneous product, even a would-be final one.
      state_d = StIdle;
      cnt_d   = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else if (bus.prod_vld) begin
      unique case (state_q)
        StIdle: begin
          acc_d   = prod_ext;
          ovf_d   = 1'b0;
          cnt_d   = CntW'(1);
          state_d = StAccum;
        end
        StAccum: begin
          if (cnt_q == CntW'(DEPTH - 1)) begin
            out_d     = sat_val;
            out_ovf_d = sat_ovf;
            vld_d     = 1'b1;
            cnt_d     = '0;
            acc_d     = '0;
            ovf_d     = 1'b0;
            state_d   = StIdle;
          end else begin
            acc_d = sat_val;
            ovf_d = sat_ovf;
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      out_q     <= '0;
      out_ovf_q <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      out_q     <= out_d;
      out_ovf_q <= out_ovf_d;
      vld_q     <= vld_d;
    end
  end

  assign bus.acc_vld = vld_q;
  assign bus.acc_out = out_q;
  assign bus.acc_ovf = out_ovf_q;
  assign bus.busy    = (cnt_q != '0);

endmodule

// File: tb/tb_mul_acc_stage.sv
// Bench for mul_acc_stage: two instances (ACC_W=18 and ACC_W=16) share one stimulus
// stream; a reference model pushes expected results to per-instance queues that are
// popped when acc_vld is seen.
module tb_mul_acc_stage;

  logic clk;
  logic rst;

  mul_acc_stage_if #(.IN_W(16), .ACC_W(18)) ifa ();
  mul_acc_stage_if #(.IN_W(16), .ACC_W(16)) ifb ();

  mul_acc_stage #(.IN_W(16), .DEPTH(4), .ACC_W(18)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  mul_acc_stage #(.IN_W(16), .DEPTH(4), .ACC_W(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Model state, index 0 = dut_a, 1 = dut_b.
  longint unsigned m_acc [2];
  bit              m_ovf [2];
  int              m_cnt [2];
  bit              e_vld [2];
  longint unsigned e_out [2];
  bit              e_ovf [2];
  logic [32:0]     q0 [$];
  logic [32:0]     q1 [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input int w, input logic v, input logic [15:0] d,
                            input logic c, input logic r);
    longint unsigned s;
    longint unsigned lim;
    bit              o;
    lim      = (64'd1 << w);
    e_vld[k] = 1'b0;
    if (r) begin
      m_acc[k] = 0; m_ovf[k] = 0; m_cnt[k] = 0; e_out[k] = 0; e_ovf[k] = 0;
    end else if (c) begin
      m_acc[k] = 0; m_ovf[k] = 0; m_cnt[k] = 0;
    end else if (v) begin
      if (m_cnt[k] == 0) begin
        m_acc[k] = d; m_ovf[k] = 0; m_cnt[k] = 1;
      end else begin
        s = m_acc[k] + d;
        o = m_ovf[k] || (s >= lim);
        if (o) s = lim - 1;
        if (m_cnt[k] == 3) begin
          e_vld[k] = 1'b1; e_out[k] = s; e_ovf[k] = o;
          if (k == 0) q0.push_back({o, s[31:0]});
          else        q1.push_back({o, s[31:0]});
          m_acc[k] = 0; m_ovf[k] = 0; m_cnt[k] = 0;
        end else begin
          m_acc[k] = s; m_ovf[k] = o; m_cnt[k]++;
        end
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [15:0] d, input logic c, input logic r);
    ifa.prod_vld = v; ifa.prod_in = d; ifa.clear = c;
    ifb.prod_vld = v; ifb.prod_in = d; ifb.clear = c;
    rst = r;
    @(posedge clk);
    model_step(0, 18, v, d, c, r);
    model_step(1, 16, v, d, c, r);
    #1;
  endtask

  task automatic grp(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                     input logic [15:0] d);
    cyc(1'b1, a, 1'b0, 1'b0);
    cyc(1'b1, b, 1'b0, 1'b0);
    cyc(1'b1, c, 1'b0, 1'b0);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  // Per-cycle scoreboard/monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [32:0] e;
    if (mon_en) begin
      check_eq("a_vld",  32'(ifa.acc_vld), 32'(e_vld[0]));
      check_eq("a_busy", 32'(ifa.busy),    32'(m_cnt[0] != 0));
      check_eq("a_hold", 32'(ifa.acc_out), e_out[0][31:0]);
      check_eq("b_vld",  32'(ifb.acc_vld), 32'(e_vld[1]));
      check_eq("b_busy", 32'(ifb.busy),    32'(m_cnt[1] != 0));
      check_eq("b_hold", 32'(ifb.acc_out), e_out[1][31:0]);
      if (ifa.acc_vld === 1'b1) begin
        check_eq("a_sb_avail", 32'(q0.size() > 0), 32'd1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          check_eq("a_sb_out", 32'(ifa.acc_out), e[31:0]);
          check_eq("a_sb_ovf", 32'(ifa.acc_ovf), 32'(e[32]));
        end
      end
      if (ifb.acc_vld === 1'b1) begin
        check_eq("b_sb_avail", 32'(q1.size() > 0), 32'd1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          check_eq("b_sb_out", 32'(ifb.acc_out), e[31:0]);
          check_eq("b_sb_ovf", 32'(ifb.acc_ovf), 32'(e[32]));
        end
      end
    end
  end

  initial begin
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    check_eq("rst_out", 32'(ifa.acc_out), 32'd0);
    check_eq("rst_vld", 32'(ifa.acc_vld), 32'd0);
    check_eq("rst_busy", 32'(ifa.busy), 32'd0);
    mon_en = 1'b1;
    idle(1);

    // Basic sum
    cyc(1'b1, 16'd3, 1'b0, 1'b0);
    check_eq("basic_busy1", 32'(ifa.busy), 32'd1);
    cyc(1'b1, 16'd5, 1'b0, 1'b0);
    cyc(1'b1, 16'd7, 1'b0, 1'b0);
    cyc(1'b1, 16'd9, 1'b0, 1'b0);
    check_eq("basic_out", 32'(ifa.acc_out), 32'd24);
    check_eq("basic_vld", 32'(ifa.acc_vld), 32'd1);
    check_eq("basic_ovf", 32'(ifa.acc_ovf), 32'd0);
    idle(1);
    check_eq("basic_pulse", 32'(ifa.acc_vld), 32'd0);
    idle(2);

    // Gaps inside a group
    cyc(1'b1, 16'd3, 1'b0, 1'b0); idle(2);
    cyc(1'b1, 16'd5, 1'b0, 1'b0); idle(2);
    cyc(1'b1, 16'd7, 1'b0, 1'b0); idle(2);
    cyc(1'b1, 16'd9, 1'b0, 1'b0);
    check_eq("gap_out", 32'(ifa.acc_out), 32'd24);
    idle(2);

    // Back-to-back groups
    grp(16'd1, 16'd2, 16'd3, 16'd4);
    check_eq("b2b_out1", 32'(ifa.acc_out), 32'd10);
    grp(16'd5, 16'd6, 16'd7, 16'd8);
    check_eq("b2b_out2", 32'(ifa.acc_out), 32'd26);
    idle(2);

    // Clear aborts a group, including its simultaneous product
    cyc(1'b1, 16'd100, 1'b0, 1'b0);
    cyc(1'b1, 16'd200, 1'b0, 1'b0);
    cyc(1'b1, 16'd50,  1'b1, 1'b0);
    check_eq("clr_busy", 32'(ifa.busy), 32'd0);
    check_eq("clr_keep", 32'(ifa.acc_out), 32'd26);
    grp(16'd1, 16'd2, 16'd3, 16'd4);
    check_eq("clr_out", 32'(ifa.acc_out), 32'd10);
    idle(1);

    // Clear on a would-be final product
    cyc(1'b1, 16'd1, 1'b0, 1'b0);
    cyc(1'b1, 16'd1, 1'b0, 1'b0);
    cyc(1'b1, 16'd1, 1'b0, 1'b0);
    cyc(1'b1, 16'd1, 1'b1, 1'b0);
    check_eq("clr_final_vld", 32'(ifa.acc_vld), 32'd0);
    idle(1);

    // Saturation on the 16-bit instance; the 18-bit one just sums
    grp(16'hFE01, 16'hFE01, 16'h0000, 16'h0001);
    check_eq("sat_out", 32'(ifb.acc_out), 32'hFFFF);
    check_eq("sat_ovf", 32'(ifb.acc_ovf), 32'd1);
    check_eq("wide_out", 32'(ifa.acc_out), 32'h1FC03);
    grp(16'd1, 16'd1, 16'd1, 16'd1);
    check_eq("post_sat_out", 32'(ifb.acc_out), 32'd4);
    check_eq("post_sat_ovf", 32'(ifb.acc_ovf), 32'd0);
    idle(1);

    // Random groups with random gaps
    for (int g = 0; g < 20; g++) begin
      for (int p = 0; p < 4; p++) begin
        cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    idle(2);

    // Reset mid-group
    cyc(1'b1, 16'd9, 1'b0, 1'b0);
    cyc(1'b1, 16'd9, 1'b0, 1'b0);
    cyc(1'b0, 16'd0, 1'b0, 1'b1);
    check_eq("mrst_out", 32'(ifa.acc_out), 32'd0);
    check_eq("mrst_ovf", 32'(ifb.acc_ovf), 32'd0);
    check_eq("mrst_vld", 32'(ifa.acc_vld), 32'd0);
    check_eq("mrst_busy", 32'(ifa.busy), 32'd0);
    grp(16'd2, 16'd2, 16'd2, 16'd2);
    check_eq("mrst_next", 32'(ifa.acc_out), 32'd8);
    idle(3);

    check_eq("a_sb_left", 32'(q0.size()), 32'd0);
    check_eq("b_sb_left", 32'(q1.size()), 32'd0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
